tournament_chooser_table: RTL and testbench

TOURNAMENT_CHOOSER_TABLE -- requirements
Module: tournament_chooser_table

---
 rtl/tournament_chooser_table_if.sv | 38 +++
 rtl/tournament_chooser_table.sv | 101 ++++++++++
 tb/tb_tournament_chooser_table.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tournament_chooser_table_if.sv
// Fetch/update/prediction signal bundle for the tournament chooser table.
// The master side drives lookups and updates. The slave side is the table itself.
interface tournament_chooser_table_if #(
    parameter int INDEX_BITS = 7,
    parameter int GHR_BITS   = 8
);
    logic                  fetch_valid;
    logic [31:0]           fetch_pc;
    logic [1:0]            fetch_local_pred;
    logic [1:0]            fetch_global_pred;
    logic                  stall;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic [1:0]            upd_sel;
    logic                  upd_actual_taken;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [1:0]            pred_sel;
    logic [1:0]            pred_local;
    logic [1:0]            pred_global;
    logic [INDEX_BITS-1:0] pred_index;
    logic [GHR_BITS-1:0]   ghr;
    logic                  init_busy;

    modport master (
        output fetch_valid, fetch_pc, fetch_local_pred, fetch_global_pred, stall,
               upd_valid, upd_index, upd_sel, upd_actual_taken,
        input  pred_valid, pred_taken, pred_sel, pred_local, pred_global,
               pred_index, ghr, init_busy
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_local_pred, fetch_global_pred, stall,
               upd_valid, upd_index, upd_sel, upd_actual_taken,
        output pred_valid, pred_taken, pred_sel, pred_local, pred_global,
               pred_index, ghr, init_busy
    );
endinterface

// File: rtl/tournament_chooser_table.sv
// Tournament chooser table: a 2-bit local/global selector per index, a 1-cycle lookup and a non-speculative GHR.
// Define TOURNAMENT_BYPASS_EN to forward a same-cycle update to a lookup of the same index.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_INIT | sweep init_cnt over the table writing 2'b01
//   ST_RUN  | lookups and MEM-stage updates are accepted
module tournament_chooser_table #(
    parameter int INDEX_BITS = 7,
    parameter int GHR_BITS   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    tournament_chooser_table_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] init_cnt;
    logic [1:0]            chooser_tbl [ENTRIES];
    logic [INDEX_BITS-1:0] fetch_index;
    logic [1:0]            lookup_sel;
    logic                  upd_fire;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_waddr;
    logic [1:0]            tbl_wdata;
    logic                  unused_pc_bits;

    assign fetch_index    = bus.fetch_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.fetch_pc[31:INDEX_BITS+2], bus.fetch_pc[1:0]};
    assign upd_fire       = (state_q == ST_RUN) && bus.upd_valid;
    assign bus.init_busy  = (state_q == ST_INIT);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tbl_we    = 1'b0;
        tbl_waddr = init_cnt;
        tbl_wdata = 2'b01;
        case (state_q)
            ST_INIT: begin
                tbl_we = 1'b1;
                if (init_cnt == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (upd_fire) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = bus.upd_index;
                    tbl_wdata = bus.upd_sel;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                    init_cnt <= '0;
        else if (state_q == ST_INIT) init_cnt <= init_cnt + INDEX_BITS'(1);
    end

    // The table itself carries no reset; the INIT sweep is what makes its contents trustworthy.
    always_ff @(posedge clk) begin
        if (!rst && tbl_we) chooser_tbl[tbl_waddr] <= tbl_wdata;
    end

`ifdef TOURNAMENT_BYPASS_EN
    assign lookup_sel = (upd_fire && (bus.upd_index == fetch_index)) ? bus.upd_sel
                                                                     : chooser_tbl[fetch_index];
`else
    assign lookup_sel = chooser_tbl[fetch_index];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pred_valid  <= 1'b0;
            bus.pred_sel    <= 2'b01;
            bus.pred_local  <= 2'b00;
            bus.pred_global <= 2'b00;
            bus.pred_index  <= '0;
        end else if (!bus.stall) begin
            bus.pred_valid  <= bus.fetch_valid && (state_q == ST_RUN);
            bus.pred_sel    <= lookup_sel;
            bus.pred_local  <= bus.fetch_local_pred;
            bus.pred_global <= bus.fetch_global_pred;
            bus.pred_index  <= fetch_index;
        end
    end

    assign bus.pred_taken = bus.pred_sel[1] ? bus.pred_global[1] : bus.pred_local[1];

    always_ff @(posedge clk) begin
        if (rst)           bus.ghr <= '0;
        else if (upd_fire) bus.ghr <= {bus.ghr[GHR_BITS-2:0], bus.upd_actual_taken};
    end
endmodule

// File: tb/tb_tournament_chooser_table.sv
// Randomized scoreboard bench for tournament_chooser_table against an array/queue reference model.
// Honours TOURNAMENT_BYPASS_EN in the model the same way the design does.
module tb_tournament_chooser_table;
    localparam int IB   = 7;
    localparam int GB   = 8;
    localparam int NENT = 1 << IB;

    typedef struct {
        int sel;
        int loc;
        int glb;
        int idx;
        int taken;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tournament_chooser_table_if #(.INDEX_BITS(IB), .GHR_BITS(GB)) bus ();
    tournament_chooser_table #(.INDEX_BITS(IB), .GHR_BITS(GB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q [$];
    int   mdl_tbl [NENT];
    int   mdl_ghr = 0;
    bit   mdl_run = 1'b0;
    int   mdl_init_left = 0;
    bit   started = 1'b0;

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Drive one cycle of stimulus, then advance the model past that edge.
    task automatic cyc(input bit r, input bit fv, input logic [31:0] pc, input int lp, input int gp,
                       input bit st, input bit uv, input int ui, input int us, input bit ut);
        int   idx;
        exp_t e;
        rst                   = r;
        bus.fetch_valid       = fv;
        bus.fetch_pc          = pc;
        bus.fetch_local_pred  = 2'(lp);
        bus.fetch_global_pred = 2'(gp);
        bus.stall             = st;
        bus.upd_valid         = uv;
        bus.upd_index         = IB'(ui);
        bus.upd_sel           = 2'(us);
        bus.upd_actual_taken  = ut;
        @(posedge clk);
        if (r) begin
            mdl_run       = 1'b0;
            mdl_init_left = NENT;
            mdl_ghr       = 0;
            started       = 1'b1;
            exp_q.delete();
        end else if (!mdl_run) begin
            if (started) begin
                mdl_init_left--;
                if (mdl_init_left == 0) begin
                    mdl_run = 1'b1;
                    foreach (mdl_tbl[i]) mdl_tbl[i] = 1;
                end
            end
        end else begin
            idx = int'(pc / 4) % NENT;
            if (fv && !st) begin
                e.sel = mdl_tbl[idx];
`ifdef TOURNAMENT_BYPASS_EN
                if (uv && ui == idx) e.sel = us;
`endif
                e.loc   = lp;
                e.glb   = gp;
                e.idx   = idx;
                e.taken = (e.sel >= 2) ? gp / 2 : lp / 2;
                exp_q.push_back(e);
            end
            if (uv) begin
                mdl_tbl[ui] = us;
                mdl_ghr     = ((mdl_ghr * 2) + int'(ut)) % (1 << GB);
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc, input int lp, input int gp);
        cyc(1'b0, 1'b1, pc, lp, gp, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic update(input int ui, input int us, input bit ut);
        cyc(1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1, ui, us, ut);
    endtask

    task automatic rand_cyc();
        cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, NENT - 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (bus.init_busy && n < 400) begin
            n++;
            idle();
        end
    endtask

    // Monitor: pops an expectation whenever a loaded edge presents pred_valid; checks hold during stalls.
    initial begin
        bit   s_stall, s_rst, have_last;
        exp_t e, last;
        have_last = 1'b0;
        forever begin
            @(posedge clk);
            s_stall = bus.stall;
            s_rst   = rst;
            @(negedge clk);
            if (started) begin
                chk("init_busy", int'(bus.init_busy), int'(!mdl_run));
                chk("ghr", int'(bus.ghr), mdl_ghr);
                if (s_rst) begin
                    have_last = 1'b0;
                    chk("rst_pred_valid", int'(bus.pred_valid), 0);
                    chk("rst_pred_sel", int'(bus.pred_sel), 1);
                    chk("rst_pred_taken", int'(bus.pred_taken), 0);
                    chk("rst_pred_index", int'(bus.pred_index), 0);
                    chk("rst_pred_local", int'(bus.pred_local), 0);
                    chk("rst_pred_global", int'(bus.pred_global), 0);
                end else if (s_stall) begin
                    if (have_last) begin
                        chk("hold_valid", int'(bus.pred_valid), 1);
                        chk("hold_sel", int'(bus.pred_sel), last.sel);
                        chk("hold_index", int'(bus.pred_index), last.idx);
                        chk("hold_local", int'(bus.pred_local), last.loc);
                        chk("hold_global", int'(bus.pred_global), last.glb);
                    end
                end else if (bus.pred_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pred_valid", 1, 0);
                        have_last = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("pred_sel", int'(bus.pred_sel), e.sel);
                        chk("pred_taken", int'(bus.pred_taken), e.taken);
                        chk("pred_local", int'(bus.pred_local), e.loc);
                        chk("pred_global", int'(bus.pred_global), e.glb);
                        chk("pred_index", int'(bus.pred_index), e.idx);
                        last      = e;
                        have_last = 1'b1;
                    end
                end else begin
                    have_last = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        cyc(1'b1, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 32'h14, 3, 3, 1'b0, 1'b1, 5, 3, 1'b1);
        count_init(n);
        chk("init_cycles", n, NENT);

        for (int i = 0; i < 8; i++) lookup($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        lookup(32'h0000_01fc, 3, 0);

        update(20, 1, 1'b1);
        update(21, 1, 1'b0);
        update(22, 1, 1'b1);
        chk("ghr_101", int'(bus.ghr), 5);

        update(5, 3, 1'b0);
        lookup(32'h14, 0, 2);
        chk("dir_sel_5", int'(bus.pred_sel), 3);
        chk("dir_taken_5", int'(bus.pred_taken), 1);

        cyc(1'b0, 1'b1, 32'h14, 0, 2, 1'b0, 1'b1, 5, 0, 1'b0);
`ifdef TOURNAMENT_BYPASS_EN
        chk("collision_sel", int'(bus.pred_sel), 0);
`else
        chk("collision_sel", int'(bus.pred_sel), 3);
`endif

        lookup(32'h24, 1, 2);
        cyc(1'b0, 1'b1, 32'h100, 3, 1, 1'b1, 1'b1, 9, 2, 1'b1);
        cyc(1'b0, 1'b1, 32'h24, 2, 3, 1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 1'b1, 32'h3c, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
        lookup(32'h24, 1, 2);
        chk("stall_upd_sel", int'(bus.pred_sel), 2);

        for (int i = 0; i < 1500; i++) rand_cyc();

        cyc(1'b1, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) rand_cyc();
        cyc(1'b1, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("midinit_ghr", int'(bus.ghr), 0);
        count_init(n);
        chk("reinit_cycles", n, NENT);
        for (int i = 0; i < 400; i++) rand_cyc();

        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
